// File: rtl/button_gesture.sv
// rtl/button_gesture.sv - classify debounced press/release events into button gestures
//
// Purpose: turns the one-tick btn_dn/btn_up events from the debouncer into
//          short press, long press, double click and auto-repeat pulses.
//          All timing is counted in ms ticks from an internal prescaler.
// Ports:
//   clk           system clock
//   rst_n         synchronous active-low reset
//   btn_dn        one-tick pulse: button became pressed
//   btn_up        one-tick pulse: button became released
//   short_press   one-tick pulse: single short press confirmed
//   long_press    one-tick pulse: hold reached LONG_MS
//   double_click  one-tick pulse: second press inside the DOUBLE_MS window
//   repeat_pulse  one-tick pulse every REPEAT_MS while held after long_press
//                 ("repeat" itself is a SystemVerilog keyword)
//   busy          level: gesture FSM not idle
module button_gesture #(
  parameter int CLK_DIV   = 100000,
  parameter int LONG_MS   = 800,
  parameter int DOUBLE_MS = 250,
  parameter int REPEAT_MS = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_dn,
  input  logic btn_up,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic repeat_pulse,
  output logic busy
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_DIV - 1);
  // Thresholds fire on the tick that would take the counter to N, so the
  // decision lands exactly N*CLK_DIV cycles after the triggering event.
  localparam logic [15:0]   LONG_LAST   = 16'(LONG_MS - 1);
  localparam logic [15:0]   DOUBLE_LAST = 16'(DOUBLE_MS - 1);
  localparam logic [15:0]   REPEAT_LAST = 16'(REPEAT_MS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    HELD   = 3'd2,
    WAIT2  = 3'd3,
    PRESS2 = 3'd4
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [PW-1:0]  presc;
  logic [15:0]    ms_cnt;
  logic           ms_tick;
  logic           dn;
  logic           up;
  logic           long_hit;
  logic           double_hit;
  logic           repeat_hit;
  logic           restart;
  logic           sp_nxt;
  logic           lp_nxt;
  logic           dc_nxt;
  logic           rp_nxt;

  // Simultaneous press and release cannot come from the debouncer; drop both.
  assign dn = btn_dn & ~btn_up;
  assign up = btn_up & ~btn_dn;

  assign ms_tick    = (presc == PRESC_LAST);
  assign long_hit   = ms_tick && (ms_cnt == LONG_LAST);
  assign double_hit = ms_tick && (ms_cnt == DOUBLE_LAST);
  assign repeat_hit = ms_tick && (ms_cnt == REPEAT_LAST);

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    sp_nxt    = 1'b0;
    lp_nxt    = 1'b0;
    dc_nxt    = 1'b0;
    rp_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (dn) begin
          state_nxt = PRESS1;
          restart   = 1'b1;
        end
      end
      PRESS1: begin
        // Release has priority over the long threshold in the same cycle.
        if (up) begin
          state_nxt = WAIT2;
          restart   = 1'b1;
        end else if (long_hit) begin
          lp_nxt    = 1'b1;
          state_nxt = HELD;
          restart   = 1'b1;
        end
      end
      HELD: begin
        if (up) begin
          state_nxt = IDLE;
          restart   = 1'b1;
        end else if (repeat_hit) begin
          rp_nxt    = 1'b1;
          restart   = 1'b1;
        end
      end
      WAIT2: begin
        // A second press on the timeout cycle still counts as a double click.
        if (dn) begin
          dc_nxt    = 1'b1;
          state_nxt = PRESS2;
          restart   = 1'b1;
        end else if (double_hit) begin
          sp_nxt    = 1'b1;
          state_nxt = IDLE;
          restart   = 1'b1;
        end
      end
      PRESS2: begin
        if (up) begin
          state_nxt = IDLE;
          restart   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        restart   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      presc        <= '0;
      ms_cnt       <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      repeat_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt != IDLE);
      short_press  <= sp_nxt;
      long_press   <= lp_nxt;
      double_click <= dc_nxt;
      repeat_pulse <= rp_nxt;
      // IDLE and PRESS2 have no timing; holding the timer at zero there
      // means the counter can never wrap.
      if (restart || state == IDLE || state == PRESS2) begin
        presc  <= '0;
        ms_cnt <= '0;
      end else if (ms_tick) begin
        presc  <= '0;
        ms_cnt <= ms_cnt + 16'd1;
      end else begin
        presc  <= presc + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_button_gesture.sv
// tb/tb_button_gesture.sv - directed self-checking bench for button_gesture
module tb_button_gesture;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_dn = 1'b0;
  logic btn_up = 1'b0;
  logic short_press, long_press, double_click, repeat_pulse, busy;

  int vectors = 0;
  int miscompares = 0;

  int dn_q[$], up_q[$], rs_q[$];
  int sp_q[$], lp_q[$], dc_q[$], rp_q[$];
  int b_q[$];

  button_gesture #(
    .CLK_DIV(4), .LONG_MS(10), .DOUBLE_MS(5), .REPEAT_MS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_dn(btn_dn), .btn_up(btn_up),
    .short_press(short_press), .long_press(long_press),
    .double_click(double_click), .repeat_pulse(repeat_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit has(input int q[$], input int k);
    foreach (q[i]) if (q[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_ranges(input int q[$], input int k);
    for (int i = 0; i + 1 < q.size(); i += 2)
      if (k >= q[i] && k <= q[i+1]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_all();
    dn_q.delete(); up_q.delete(); rs_q.delete();
    sp_q.delete(); lp_q.delete(); dc_q.delete(); rp_q.delete();
    b_q.delete();
  endtask

  // Cycle k = interval after posedge k; inputs driven in cycle k are sampled
  // at posedge k+1, and outputs registered at posedge k are checked in cycle k.
  task automatic run(input string name, input int len);
    logic [4:0] obs, exp;
    rst_n = 1'b0; btn_dn = 1'b0; btn_up = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    obs = {short_press, long_press, double_click, repeat_pulse, busy};
    vectors++;
    assert (obs === 5'b0) else begin
      miscompares++;
      $error("FAIL %s reset: got %b want %b", name, obs, 5'b0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < len; k++) begin
      obs = {short_press, long_press, double_click, repeat_pulse, busy};
      exp = {has(sp_q, k), has(lp_q, k), has(dc_q, k), has(rp_q, k), in_ranges(b_q, k)};
      vectors++;
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s cyc %0d: got %b want %b (sp lp dc rp busy)", name, k, obs, exp);
      end
      btn_dn = has(dn_q, k);
      btn_up = has(up_q, k);
      rst_n  = !has(rs_q, k);
      @(posedge clk); #1;
    end
    btn_dn = 1'b0; btn_up = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    // Short press: release at 12, window of 20 cycles expires -> short at 33.
    clear_all();
    dn_q = '{0}; up_q = '{12}; sp_q = '{33}; b_q = '{1, 32};
    run("short", 45);

    // Long press with repeats; repeat due at 101 is cancelled by release at 100.
    clear_all();
    dn_q = '{0}; up_q = '{100}; lp_q = '{41}; rp_q = '{53, 65, 77, 89}; b_q = '{1, 100};
    run("long_rep", 115);

    // Double click.
    clear_all();
    dn_q = '{0, 16}; up_q = '{8, 30}; dc_q = '{17}; b_q = '{1, 30};
    run("double", 45);

    // Second press exactly on the window timeout: double click wins.
    clear_all();
    dn_q = '{0, 28}; up_q = '{8, 40}; dc_q = '{29}; b_q = '{1, 40};
    run("edge_dc", 50);

    // Second press one cycle late: short press, then a fresh gesture.
    clear_all();
    dn_q = '{0, 29}; up_q = '{8, 35}; sp_q = '{29, 56}; b_q = '{1, 28, 30, 55};
    run("edge_sp", 65);

    // Release coinciding with the long threshold: no long press.
    clear_all();
    dn_q = '{0}; up_q = '{40}; sp_q = '{61}; b_q = '{1, 60};
    run("long_tie", 70);

    // Reset while HELD discards the gesture; later release is ignored.
    clear_all();
    dn_q = '{0}; up_q = '{60}; rs_q = '{45, 46}; lp_q = '{41}; b_q = '{1, 45};
    run("rst_held", 70);

    // Simultaneous press/release is ignored in IDLE.
    clear_all();
    dn_q = '{3, 10}; up_q = '{3, 20}; b_q = '{11, 40};
    sp_q = '{41};
    run("both_high", 50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
